// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO for the execute stage.
// Optional macro MULDIV_EARLY_EXIT_EN: short divides (|dividend| < |divisor|) finish in one cycle.
module muldiv_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        id_valid,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        arith_stall
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] prod_q;
  logic [31:0] rem_q, quo_q, dvs_q, a_q;
  logic        neg_q, neg_r, dz_q;

  logic        idle_like, accept, early;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [63:0] a_ext, b_ext, prod_in;
  logic [32:0] trial, diff;
  logic [31:0] rem_n, quo_n, quo_fix, rem_fix, lo_res, hi_res;
  logic        mul_last, div_last;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign accept    = start & id_valid & ~cancel & idle_like;
  assign arith_stall = busy | accept;

  // op[0]=0 selects the signed flavour of both MULT and DIV
  assign a_neg   = ~op[0] & src_a[31];
  assign b_neg   = ~op[0] & src_b[31];
  assign abs_a   = a_neg ? -src_a : src_a;
  assign abs_b   = b_neg ? -src_b : src_b;
  assign a_ext   = {{32{a_neg}}, src_a};
  assign b_ext   = {{32{b_neg}}, src_b};
  assign prod_in = a_ext * b_ext;

`ifdef MULDIV_EARLY_EXIT_EN
  assign early = op[1] & (abs_b != 32'd0) & (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // One restoring step; the dividend shifts out of quo_q as quotient bits shift in
  always_comb begin
    trial = {rem_q, quo_q[31]};
    diff  = trial - {1'b0, dvs_q};
    rem_n = trial[31:0];
    quo_n = {quo_q[30:0], 1'b0};
    if (!diff[32]) begin
      rem_n = diff[31:0];
      quo_n = {quo_q[30:0], 1'b1};
    end
  end

  assign quo_fix  = neg_q ? -quo_n : quo_n;
  assign rem_fix  = neg_r ? -rem_n : rem_n;
  assign lo_res   = dz_q ? 32'hFFFF_FFFF : quo_fix;
  assign hi_res   = dz_q ? a_q : rem_fix;
  assign mul_last = (MUL_CYCLES >= 2) && (cnt == 5'(MUL_CYCLES - 2));
  assign div_last = (cnt == 5'(DIV_ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      hi_out <= 32'd0;
      lo_out <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      prod_q <= 64'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      a_q    <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (hi_we) hi_out <= wdata;
          if (lo_we) lo_out <= wdata;
          if (accept) begin
            cnt <= 5'd0;
            if (!op[1]) begin
              prod_q <= prod_in;
              if (MUL_CYCLES == 1) begin
                state  <= S_DONE;
                done   <= 1'b1;
                hi_out <= prod_in[63:32];
                lo_out <= prod_in[31:0];
              end else begin
                state <= S_MUL;
                busy  <= 1'b1;
              end
            end else if (early) begin
              state  <= S_DONE;
              done   <= 1'b1;
              hi_out <= src_a;
              lo_out <= 32'd0;
            end else begin
              state <= S_DIV;
              busy  <= 1'b1;
              rem_q <= 32'd0;
              quo_q <= abs_a << (32 - DIV_ITERS);
              dvs_q <= abs_b;
              a_q   <= src_a;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              dz_q  <= (src_b == 32'd0);
            end
          end
        end
        S_MUL: begin
          cnt <= (cnt == 5'h1F) ? cnt : cnt + 5'd1;
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (mul_last) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            hi_out <= prod_q[63:32];
            lo_out <= prod_q[31:0];
          end
        end
        S_DIV: begin
          cnt <= (cnt == 5'h1F) ? cnt : cnt + 5'd1;
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            if (div_last) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              hi_out <= hi_res;
              lo_out <= lo_res;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus random ops against an arithmetic model.
module tb_muldiv_ctrl;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_ITERS  = 32;

  logic        clk = 1'b0;
  logic        rst, start, id_valid, cancel, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata, hi_out, lo_out;
  logic        busy, done, arith_stall;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITERS(DIV_ITERS)) dut (
    .clk(clk), .rst(rst), .start(start), .id_valid(id_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .arith_stall(arith_stall)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 0; id_valid = 0; cancel = 0; hi_we = 0; lo_we = 0;
  endtask

  // Expected {HI,LO} straight from the arithmetic definition of each op
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int sa, sb;
    sa = a;
    sb = b;
    case (o)
      2'b00: r = 64'(longint'(sa) * longint'(sb));
      2'b01: r = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] aa, bb;
    aa = (o == 2'b10 && a[31]) ? 32'(-a) : a;
    bb = (o == 2'b10 && b[31]) ? 32'(-b) : b;
    if (!o[1]) return MUL_CYCLES;
`ifdef MULDIV_EARLY_EXIT_EN
    if (bb != 32'd0 && aa < bb) return 1;
`endif
    if (aa == bb) return DIV_ITERS + 1;
    return DIV_ITERS + 1;
  endfunction

  // Launches one op and returns the cycle done appeared in plus a count of stall/busy violations
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int sbad);
    lat = -1;
    sbad = 0;
    start = 1; id_valid = 1; op = o; src_a = a; src_b = b;
    #1;
    for (int c = 0; c < 200; c++) begin
      if (c > 0 && done) begin
        lat = c;
        if (arith_stall !== 1'b0 || busy !== 1'b0) sbad++;
        break;
      end
      if (arith_stall !== 1'b1) sbad++;
      if (c > 0 && busy !== 1'b1) sbad++;
      tick;
      start = 0; id_valid = 0;
      #1;
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat, sbad;
    logic [63:0] exp;
    int elat;
    exp  = model(o, a, b);
    elat = model_lat(o, a, b);
    do_op(o, a, b, lat, sbad);
    total++;
    if (lat !== elat) begin bad++; $display("[TB] FAIL %s latency got=%0d want=%0d", name, lat, elat); end
    total++;
    if ({hi_out, lo_out} !== exp) begin
      bad++; $display("[TB] FAIL %s result op=%0d a=%h b=%h got=%h_%h want=%h", name, o, a, b, hi_out, lo_out, exp);
    end
    total++;
    if (sbad !== 0) begin bad++; $display("[TB] FAIL %s stall/busy violations got=%0d want=0", name, sbad); end
  endtask

  task automatic test_reset;
    rst = 1; idle_inputs(); op = 0; src_a = 0; src_b = 0; wdata = 0;
    tick; tick;
    total++; if (hi_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_hi got=%h want=0", hi_out); end
    total++; if (lo_out !== 32'd0) begin bad++; $display("[TB] FAIL reset_lo got=%h want=0", lo_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (arith_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b want=0", arith_stall); end
    rst = 0;
    tick;
  endtask

  task automatic test_mul;
    check_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3);
    tick;
    check_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick;
    check_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);
    tick;
  endtask

  task automatic test_div;
    check_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    tick;
    check_op("divu_by0", 2'b11, 32'd100, 32'd0);
    tick;
    check_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'd0);
    tick;
    check_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    tick;
    check_op("divu_3_10", 2'b11, 32'd3, 32'd10);
    tick;
    check_op("div_small_neg", 2'b10, 32'hFFFF_FFFD, 32'd10);
    tick;
    check_op("divu_0_5", 2'b11, 32'd0, 32'd5);
    tick;
  endtask

  task automatic test_cancel;
    logic saw_done;
    hi_we = 1; lo_we = 1; wdata = 32'hAAAA_5555;
    tick;
    hi_we = 0; lo_we = 0;
    total++; if (hi_out !== 32'hAAAA_5555) begin bad++; $display("[TB] FAIL mthi got=%h want=aaaa5555", hi_out); end
    lo_we = 1; wdata = 32'h1234_5678;
    tick;
    lo_we = 0;
    total++; if (lo_out !== 32'h1234_5678) begin bad++; $display("[TB] FAIL mtlo got=%h want=12345678", lo_out); end
    // cancel wins over a simultaneous start
    start = 1; id_valid = 1; cancel = 1; op = 2'b11; src_a = 32'd9; src_b = 32'd2;
    #1;
    total++; if (arith_stall !== 1'b0) begin bad++; $display("[TB] FAIL cancel_vs_start_stall got=%b want=0", arith_stall); end
    tick;
    idle_inputs();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cancel_vs_start_busy got=%b want=0", busy); end
    // DIVU 100/7 cancelled in cycle 10
    saw_done = 0;
    start = 1; id_valid = 1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      tick;
      start = 0; id_valid = 0;
      if (done) saw_done = 1;
    end
    cancel = 1;
    tick;
    cancel = 0;
    if (done) saw_done = 1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cancel_busy got=%b want=0", busy); end
    total++; if (saw_done !== 1'b0) begin bad++; $display("[TB] FAIL cancel_done got=%b want=0", saw_done); end
    total++; if ({hi_out, lo_out} !== {32'hAAAA_5555, 32'h1234_5678}) begin
      bad++; $display("[TB] FAIL cancel_hilo got=%h_%h want=aaaa5555_12345678", hi_out, lo_out);
    end
    tick;
    check_op("after_cancel", 2'b01, 32'd5, 32'd6);
    tick;
  endtask

  task automatic test_busy_ignores;
    int lat;
    lat = -1;
    start = 1; id_valid = 1; op = 2'b01; src_a = 32'd7; src_b = 32'd9;
    tick;
    start = 1; id_valid = 1; op = 2'b11; src_a = 32'd1; src_b = 32'd1; hi_we = 1; lo_we = 1; wdata = 32'hDEAD_BEEF;
    tick;
    idle_inputs();
    for (int c = 2; c < 20; c++) begin
      if (done) begin lat = c; break; end
      tick;
    end
    total++; if (lat !== MUL_CYCLES) begin bad++; $display("[TB] FAIL busy_ignore_lat got=%0d want=%0d", lat, MUL_CYCLES); end
    total++; if ({hi_out, lo_out} !== 64'd63) begin bad++; $display("[TB] FAIL busy_ignore_result got=%h_%h want=63", hi_out, lo_out); end
    tick;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL busy_ignore_idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_write_in_done;
    int lat, sbad;
    logic [63:0] exp;
    exp = model(2'b00, 32'h0001_2345, 32'hFFFF_FFFD);
    do_op(2'b00, 32'h0001_2345, 32'hFFFF_FFFD, lat, sbad);
    hi_we = 1; wdata = 32'h0000_1234;
    tick;
    hi_we = 0;
    total++; if (hi_out !== 32'h0000_1234) begin bad++; $display("[TB] FAIL done_write_hi got=%h want=00001234", hi_out); end
    total++; if (lo_out !== exp[31:0]) begin bad++; $display("[TB] FAIL done_write_lo got=%h want=%h", lo_out, exp[31:0]); end
  endtask

  task automatic test_back_to_back;
    check_op("b2b_first", 2'b10, 32'd1000, 32'hFFFF_FFF9);
    check_op("b2b_second", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    check_op("b2b_third", 2'b11, 32'hFFFF_FFFF, 32'd3);
    tick;
  endtask

  task automatic test_reset_mid;
    hi_we = 1; lo_we = 1; wdata = 32'h5A5A_A5A5;
    tick;
    hi_we = 0; lo_we = 0;
    start = 1; id_valid = 1; op = 2'b10; src_a = 32'd12345; src_b = 32'd17;
    for (int c = 1; c <= 5; c++) begin
      tick;
      start = 0; id_valid = 0;
    end
    rst = 1;
    tick;
    rst = 0;
    total++; if ({hi_out, lo_out} !== 64'd0) begin bad++; $display("[TB] FAIL midrst_hilo got=%h_%h want=0", hi_out, lo_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
    total++; if (arith_stall !== 1'b0) begin bad++; $display("[TB] FAIL midrst_stall got=%b want=0", arith_stall); end
    tick;
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'd0;
        3: b = -32'($urandom_range(1, 20));
        default: b = 32'($urandom_range(0, 100000));
      endcase
      check_op($sformatf("rand%0d", i), o, a, b);
      if ($urandom_range(0, 1) == 1) tick;
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_cancel();
    test_busy_ignores();
    test_write_in_done();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
